// File: rtl/sprite_palette_scheduler.sv
// sprite_palette_scheduler
// Shares one 16-entry sprite palette between N_LAYERS overlapping sprite
// layers for a single screen pixel. A request latches the hit mask, the
// per-layer colour indices and the background colour. The hit layers are
// then visited in priority order (layer 0 first), one palette lookup per
// cycle. Layers whose palette colour equals the transparency key are
// skipped. The first opaque colour is returned, or the background colour
// when no opaque layer is found.
module sprite_palette_scheduler #(
  parameter int unsigned N_LAYERS = 4,
  parameter logic [11:0] KEY_RGB  = 12'hF0D,
  localparam int unsigned LW      = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  pix_start_i,
  input  logic [N_LAYERS-1:0]   layer_hit_i,
  input  logic [4*N_LAYERS-1:0] layer_index_i,
  input  logic [11:0]           bg_rgb_i,
  output logic [3:0]            pal_index_o,
  input  logic [11:0]           pal_rgb_i,
  output logic [11:0]           rgb_out_o,
  output logic                  pix_valid_o,
  output logic                  win_valid_o,
  output logic [LW-1:0]         win_layer_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  input  logic                  overrun_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Position of the lowest set bit, i.e. the highest-priority pending layer.
  function automatic logic [LW-1:0] lowest_set(input logic [N_LAYERS-1:0] mask);
    logic [LW-1:0] pos;
    pos = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        pos = LW'(i);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

  state_e                  state_q, state_d;
  logic [N_LAYERS-1:0]     pending_q, pending_d;
  logic [4*N_LAYERS-1:0]   idx_q, idx_d;
  logic [11:0]             bg_q, bg_d;
  logic [11:0]             rgb_q, rgb_d;
  logic                    win_valid_q, win_valid_d;
  logic [LW-1:0]           win_layer_q, win_layer_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic [LW-1:0]           sel_s;
  logic                    scan_active_s;
  logic [3:0]              pal_index_s;

  // Next-state, palette address and result selection.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    idx_d       = idx_q;
    bg_d        = bg_q;
    rgb_d       = rgb_q;
    win_valid_d = win_valid_q;
    win_layer_d = win_layer_q;

    // The palette is addressed combinationally so its colour can be judged
    // in the same cycle; it is parked at 0 whenever no layer is examined.
    sel_s         = lowest_set(pending_q);
    scan_active_s = (state_q == ST_SCAN) && (pending_q != '0);
    if (scan_active_s) begin
      pal_index_s = idx_q[{sel_s, 2'b00} +: 4];
    end else begin
      pal_index_s = 4'd0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pix_start_i) begin
          pending_d = layer_hit_i;
          idx_d     = layer_index_i;
          bg_d      = bg_rgb_i;
          state_d   = ST_SCAN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (pending_q == '0) begin
          // Nothing opaque left: fall back to the latched background.
          rgb_d       = bg_q;
          win_valid_d = 1'b0;
          win_layer_d = '0;
          state_d     = ST_DONE;
        end else if (pal_rgb_i != KEY_RGB) begin
          rgb_d       = pal_rgb_i;
          win_valid_d = 1'b1;
          win_layer_d = sel_s;
          state_d     = ST_DONE;
        end else begin
          // Transparent: drop this layer and look at the next one.
          pending_d[sel_s] = 1'b0;
          state_d          = ST_SCAN;
        end
      end
      ST_DONE: begin
        // A request here restarts immediately, giving back-to-back pixels.
        if (pix_start_i) begin
          pending_d = layer_hit_i;
          idx_d     = layer_index_i;
          bg_d      = bg_rgb_i;
          state_d   = ST_SCAN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A request while scanning is dropped and flagged; setting beats clearing.
    if ((state_q == ST_SCAN) && pix_start_i) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    pix_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_SCAN);
  end

  // State, latched request and registered result with asynchronous reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      idx_q       <= '0;
      bg_q        <= 12'h000;
      rgb_q       <= 12'h000;
      win_valid_q <= 1'b0;
      win_layer_q <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      bg_q        <= bg_d;
      rgb_q       <= rgb_d;
      win_valid_q <= win_valid_d;
      win_layer_q <= win_layer_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pal_index_o = pal_index_s;
  assign rgb_out_o   = rgb_q;
  assign pix_valid_o = pix_valid_q;
  assign win_valid_o = win_valid_q;
  assign win_layer_o = win_layer_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sprite_palette_scheduler.sv
// Directed bench for sprite_palette_scheduler with a behavioural palette.
module tb_sprite_palette_scheduler;

  localparam int N = 4;

  logic          clk;
  logic          reset_n;
  logic          pix_start;
  logic [N-1:0]  layer_hit;
  logic [4*N-1:0] layer_index;
  logic [11:0]   bg_rgb;
  logic [3:0]    pal_index;
  logic [11:0]   pal_rgb;
  logic [11:0]   rgb_out;
  logic          pix_valid;
  logic          win_valid;
  logic [1:0]    win_layer;
  logic          busy;
  logic          overrun;
  logic          overrun_clr;

  logic [11:0]   palette [16];

  int checks;
  int failures;

  sprite_palette_scheduler #(.N_LAYERS(N), .KEY_RGB(12'hF0D)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .pix_start_i   (pix_start),
    .layer_hit_i   (layer_hit),
    .layer_index_i (layer_index),
    .bg_rgb_i      (bg_rgb),
    .pal_index_o   (pal_index),
    .pal_rgb_i     (pal_rgb),
    .rgb_out_o     (rgb_out),
    .pix_valid_o   (pix_valid),
    .win_valid_o   (win_valid),
    .win_layer_o   (win_layer),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr)
  );

  assign pal_rgb = palette[pal_index];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and clock it in; afterwards the DUT is in SCAN.
  task automatic start_pixel(input logic [N-1:0] hit, input logic [4*N-1:0] idx,
                             input logic [11:0] bg);
    layer_hit   = hit;
    layer_index = idx;
    bg_rgb      = bg;
    pix_start   = 1'b1;
    tick();
    pix_start   = 1'b0;
  endtask

  // Expect k skipped layers, then a one-cycle result, then idle.
  task automatic expect_result(input int k, input logic [11:0] rgb,
                               input logic wv, input logic [1:0] wl);
    for (int i = 0; i <= k; i++) begin
      chk("scan_pix_valid", 32'(pix_valid), 32'(1'b0));
      chk("scan_busy", 32'(busy), 32'(1'b1));
      tick();
    end
    chk("res_pix_valid", 32'(pix_valid), 32'(1'b1));
    chk("res_busy", 32'(busy), 32'(1'b0));
    chk("res_rgb", 32'(rgb_out), 32'(rgb));
    chk("res_win_valid", 32'(win_valid), 32'(wv));
    chk("res_win_layer", 32'(win_layer), 32'(wl));
    tick();
    chk("post_pix_valid", 32'(pix_valid), 32'(1'b0));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b1;
    pix_start   = 1'b0;
    overrun_clr = 1'b0;
    layer_hit   = '0;
    layer_index = '0;
    bg_rgb      = 12'h000;
    for (int i = 0; i < 16; i++) palette[i] = {3{4'(i)}};
    palette[0] = 12'hF0D;
    palette[3] = 12'hFFF;
    palette[5] = 12'hFFF;
    palette[9] = 12'hF0D;

    // Power-on reset
    #3 reset_n = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb_out), 32'(12'h000));
    chk("rst_pix_valid", 32'(pix_valid), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_pal_index", 32'(pal_index), 32'(4'd0));
    chk("idle_overrun", 32'(overrun), 32'(1'b0));
    chk("idle_win_valid", 32'(win_valid), 32'(1'b0));

    // Single opaque layer 2, index 3 -> FFF
    start_pixel(4'b0100, 16'h0300, 12'h123);
    chk("single_pal_index", 32'(pal_index), 32'(4'd3));
    expect_result(0, 12'hFFF, 1'b1, 2'd2);

    // Layer 0 transparent (index 0), layer 1 index 5 -> FFF
    start_pixel(4'b0011, 16'h0050, 12'h123);
    chk("skip_pal_first", 32'(pal_index), 32'(4'd0));
    tick();
    chk("skip_pal_second", 32'(pal_index), 32'(4'd5));
    chk("skip_pix_valid", 32'(pix_valid), 32'(1'b0));
    tick();
    chk("skip_pix_valid_res", 32'(pix_valid), 32'(1'b1));
    chk("skip_rgb", 32'(rgb_out), 32'(12'hFFF));
    chk("skip_win_layer", 32'(win_layer), 32'(2'd1));
    tick();
    chk("skip_pal_idle", 32'(pal_index), 32'(4'd0));

    // Transparency judged by colour: index 9 also maps to the key colour
    start_pixel(4'b1010, 16'h2090, 12'h321);
    expect_result(1, 12'h222, 1'b1, 2'd3);

    // Empty hit mask -> background
    start_pixel(4'b0000, 16'h3333, 12'h0A5);
    expect_result(0, 12'h0A5, 1'b0, 2'd0);

    // All four layers transparent; inputs change mid-scan and must be ignored
    start_pixel(4'b1111, 16'h0000, 12'h0A5);
    layer_hit   = 4'b0001;
    layer_index = 16'h3333;
    bg_rgb      = 12'h777;
    expect_result(4, 12'h0A5, 1'b0, 2'd0);

    // Overrun: request during SCAN is dropped, result unaffected
    start_pixel(4'b1111, 16'h0300, 12'h456);
    chk("ovr_before", 32'(overrun), 32'(1'b0));
    layer_hit = 4'b0000;
    bg_rgb    = 12'h0AA;
    pix_start = 1'b1;
    tick();
    pix_start = 1'b0;
    chk("ovr_set", 32'(overrun), 32'(1'b1));
    chk("ovr_pix_valid_a", 32'(pix_valid), 32'(1'b0));
    tick();
    chk("ovr_pix_valid_b", 32'(pix_valid), 32'(1'b0));
    tick();
    chk("ovr_pix_valid_res", 32'(pix_valid), 32'(1'b1));
    chk("ovr_rgb", 32'(rgb_out), 32'(12'hFFF));
    chk("ovr_win_layer", 32'(win_layer), 32'(2'd2));
    tick();
    chk("ovr_no_extra_valid", 32'(pix_valid), 32'(1'b0));
    chk("ovr_no_extra_busy", 32'(busy), 32'(1'b0));

    // Set and clear in the same cycle: set wins
    start_pixel(4'b0011, 16'h0000, 12'h456);
    pix_start   = 1'b1;
    overrun_clr = 1'b1;
    tick();
    pix_start   = 1'b0;
    overrun_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'(1'b1));
    tick();
    tick();
    chk("ovr2_pix_valid", 32'(pix_valid), 32'(1'b1));
    chk("ovr2_rgb", 32'(rgb_out), 32'(12'h456));
    chk("ovr2_win_valid", 32'(win_valid), 32'(1'b0));
    tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'(1'b0));

    // Back-to-back: second request presented in DONE
    start_pixel(4'b0100, 16'h0300, 12'h123);
    tick();
    chk("b2b_first_valid", 32'(pix_valid), 32'(1'b1));
    chk("b2b_first_rgb", 32'(rgb_out), 32'(12'hFFF));
    layer_hit   = 4'b0001;
    layer_index = 16'h0002;
    pix_start   = 1'b1;
    tick();
    pix_start   = 1'b0;
    chk("b2b_gap_valid", 32'(pix_valid), 32'(1'b0));
    chk("b2b_gap_busy", 32'(busy), 32'(1'b1));
    chk("b2b_no_overrun", 32'(overrun), 32'(1'b0));
    tick();
    chk("b2b_second_valid", 32'(pix_valid), 32'(1'b1));
    chk("b2b_second_rgb", 32'(rgb_out), 32'(12'h222));
    chk("b2b_second_layer", 32'(win_layer), 32'(2'd0));
    tick();

    // Reset in the middle of a scan
    start_pixel(4'b1111, 16'h9999, 12'h777);
    pix_start = 1'b1;
    tick();
    pix_start = 1'b0;
    chk("mid_overrun", 32'(overrun), 32'(1'b1));
    chk("mid_pal_index", 32'(pal_index), 32'(4'd9));
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_rgb", 32'(rgb_out), 32'(12'h000));
    chk("mrst_busy", 32'(busy), 32'(1'b0));
    chk("mrst_overrun", 32'(overrun), 32'(1'b0));
    chk("mrst_pal_index", 32'(pal_index), 32'(4'd0));
    chk("mrst_win_valid", 32'(win_valid), 32'(1'b0));
    chk("mrst_win_layer", 32'(win_layer), 32'(2'd0));
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_no_valid", 32'(pix_valid), 32'(1'b0));
      chk("mrst_idle_busy", 32'(busy), 32'(1'b0));
    end
    start_pixel(4'b0100, 16'h0300, 12'h123);
    expect_result(0, 12'hFFF, 1'b1, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
